rs_issue_scheduler: RTL and testbench
=====================================

# rs_issue_scheduler

Reservation-station scheduler between the 2-wide dispatch stage and the functional units. It holds up to 16 renamed instructions and captures operands from writeback broadcasts (wakeup). Each cycle it selects up to one ready instruction per free functional unit and issues it with both operand values. It owns RS entry allocation, deallocation and flush.

## Interface
Parameters:
- RS_DEPTH, 16, number of reservation-station rows
- NUM_FU, 3, functional units (issue ports and writeback ports)
- PREG_W, 6, physical register tag width
- DATA_W, 32, operand width
- ROB_W, 4, ROB index width

Ports (per-slot/per-FU fields are packed arrays `[N-1:0][W-1:0]`):
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all rows and issue outputs
- disp_valid  in  2  dispatch slot valids (slot 0 older)
- disp_op  in  2x7  opcode
- disp_pd  in  2xPREG_W  destination physical reg
- disp_ps1, disp_ps2  in  2xPREG_W  source tags
- disp_src1_rdy, disp_src2_rdy  in  2  source ready per ready-table
- disp_src1_data, disp_src2_data  in  2xDATA_W  source values, meaningful when ready
- disp_rob  in  2xROB_W  ROB index
- disp_ready  out  1  at least 2 free rows; dispatch accepted only when high
- rs_free_cnt  out  5  free row count
- wb_valid  in  NUM_FU  writeback broadcast valid
- wb_tag  in  NUM_FUxPREG_W  written physical reg
- wb_data  in  NUM_FUxDATA_W  written value
- fu_ready  in  NUM_FU  FU can accept an instruction this cycle
- iss_valid  out  NUM_FU  registered issue valid
- iss_op, iss_pd, iss_rob, iss_data1, iss_data2  out  per FU  issued fields

## Operation
- Row fields: valid, op, pd, ps1, data1, rdy1, ps2, data2, rdy2, rob.
- Allocation: slot 0 takes lowest-index free row, slot 1 the next lowest. Free means valid=0 at cycle start; rows freed by issue this cycle are reusable next cycle. Dispatch when disp_ready=0 is ignored, with no state change. Slot 1 valid without slot 0 is legal.
- Source tag 0 is always ready with data 0, regardless of disp_srcN_rdy.
- Wakeup: for every valid row source with rdy=0 and a matching wb_tag on a valid wb port, set rdy=1 and capture wb_data. Same-cycle dispatch sources are also compared against wb. If several wb ports match one tag, the lowest port wins.
- Eligible row: valid, rdy1=1 and rdy2=1, as registered at cycle start. Wakeup in cycle N makes a row eligible in cycle N+1, not N.
- Select: walk FUs 0..NUM_FU-1. Each FU with fu_ready=1 takes the lowest-index eligible row not yet granted. FUs with fu_ready=0 get nothing. Remaining eligible rows wait. A row issues at most once.
- Issue: granted rows clear valid. Their fields register onto iss_* of the granting FU, with iss_valid=1 for one cycle. Ungranted FUs get iss_valid=0; their data outputs hold their previous value.
- flush: at the next edge all valid=0, iss_valid=0, and dispatch/wakeup that cycle are discarded. flush has priority over everything except rst_n.
- rs_free_cnt and disp_ready are combinational from registered valid bits.

## Timing
- Reset (async assert, sync-effective deassert): all rows invalid, iss_valid=0, iss_* data/fields=0, rs_free_cnt=16, disp_ready=1.
- Dispatch at edge N with ready operands → iss_valid at edge N+1 (1-cycle minimum latency).
- Wakeup at edge N for a dispatched row → issue at edge N+1.
- Dispatch with wb-matching source in the same cycle → captured ready at edge N, issue at edge N+1.
- Full: rs_free_cnt<2 → disp_ready=0. With 1 free row, single-slot dispatch is still refused.
- Reset mid-operation clears all state immediately; in-flight issue is lost.

## Test plan
- Reset → rs_free_cnt=16, disp_ready=1, iss_valid=0; 2 ready instrs (pd=33,34) dispatched → next edge iss_valid=3'b011, FU0 pd=33, FU1 pd=34, free count back to 16.
- Dispatch row with ps1=40 not ready; wb_valid[2] tag=40 data=0xDEAD two cycles later → issue one cycle after wb with iss_data1=0xDEAD.
- Fill 14 rows not ready → rs_free_cnt=2, disp_ready=1; dispatch 2 more → disp_ready=0; further disp_valid is ignored and count stays 0.
- 5 eligible rows, fu_ready=3'b101 → FU0 gets row 0, FU2 gets row 1, FU1 iss_valid=0; next cycle with all ready → rows 2,3,4.
- Dispatch source ps2=45 while wb tag=45 data=7 in the same cycle → issues next edge with iss_data2=7.
- 10 valid rows, assert flush → next edge rs_free_cnt=16, iss_valid=0; assert rst_n low mid-issue → outputs zero immediately.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: 2-wide allocation, writeback wakeup and
// per-FU oldest-index select. Row control state is reset; row payload is not.
module rs_issue_scheduler #(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [1:0]                    disp_valid,
  input  logic [1:0][6:0]               disp_op,
  input  logic [1:0][PREG_W-1:0]        disp_pd,
  input  logic [1:0][PREG_W-1:0]        disp_ps1,
  input  logic [1:0][PREG_W-1:0]        disp_ps2,
  input  logic [1:0]                    disp_src1_rdy,
  input  logic [1:0]                    disp_src2_rdy,
  input  logic [1:0][DATA_W-1:0]        disp_src1_data,
  input  logic [1:0][DATA_W-1:0]        disp_src2_data,
  input  logic [1:0][ROB_W-1:0]         disp_rob,
  output logic                          disp_ready,
  output logic [4:0]                    rs_free_cnt,
  input  logic [NUM_FU-1:0]             wb_valid,
  input  logic [NUM_FU-1:0][PREG_W-1:0] wb_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0] wb_data,
  input  logic [NUM_FU-1:0]             fu_ready,
  output logic [NUM_FU-1:0]             iss_valid,
  output logic [NUM_FU-1:0][6:0]        iss_op,
  output logic [NUM_FU-1:0][PREG_W-1:0] iss_pd,
  output logic [NUM_FU-1:0][ROB_W-1:0]  iss_rob,
  output logic [NUM_FU-1:0][DATA_W-1:0] iss_data1,
  output logic [NUM_FU-1:0][DATA_W-1:0] iss_data2
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } wb_res_t;

  logic [RS_DEPTH-1:0] r_valid;
  logic [RS_DEPTH-1:0] r_rdy1;
  logic [RS_DEPTH-1:0] r_rdy2;
  logic [6:0]          r_op    [RS_DEPTH];
  logic [PREG_W-1:0]   r_pd    [RS_DEPTH];
  logic [PREG_W-1:0]   r_ps1   [RS_DEPTH];
  logic [PREG_W-1:0]   r_ps2   [RS_DEPTH];
  logic [DATA_W-1:0]   r_data1 [RS_DEPTH];
  logic [DATA_W-1:0]   r_data2 [RS_DEPTH];
  logic [ROB_W-1:0]    r_rob   [RS_DEPTH];

  logic [4:0]                    w_free_cnt;
  logic [IDX_W-1:0]              w_free0;
  logic [IDX_W-1:0]              w_free1;
  logic                          w_have0;
  logic                          w_have1;
  logic [1:0]                    w_alloc_en;
  logic [1:0][IDX_W-1:0]         w_alloc_idx;
  logic [1:0][DATA_W:0]          w_src1;
  logic [1:0][DATA_W:0]          w_src2;
  logic [RS_DEPTH-1:0]           w_elig;
  logic [RS_DEPTH-1:0]           w_taken;
  logic [NUM_FU-1:0]             w_grant;
  logic [NUM_FU-1:0][IDX_W-1:0]  w_grant_idx;
  logic [RS_DEPTH-1:0]           w_wk1;
  logic [RS_DEPTH-1:0]           w_wk2;
  wb_res_t                       w_wb1 [RS_DEPTH];
  wb_res_t                       w_wb2 [RS_DEPTH];

  // Lowest-numbered matching writeback port wins.
  function automatic wb_res_t wb_lookup(input logic [PREG_W-1:0] tag);
    wb_res_t res;
    res = '0;
    for (int f = NUM_FU - 1; f >= 0; f--) begin
      if (wb_valid[f] && (wb_tag[f] == tag)) begin
        res.hit  = 1'b1;
        res.data = wb_data[f];
      end
    end
    return res;
  endfunction

  // Returns {ready, value} for a source entering the station this cycle.
  function automatic logic [DATA_W:0] src_resolve(input logic [PREG_W-1:0] tag,
                                                  input logic              rdy,
                                                  input logic [DATA_W-1:0] data);
    wb_res_t wb;
    wb = wb_lookup(tag);
    if (tag == '0)  return {1'b1, {DATA_W{1'b0}}};
    else if (rdy)   return {1'b1, data};
    else if (wb.hit) return {1'b1, wb.data};
    else            return {1'b0, data};
  endfunction

  always_comb begin
    w_free_cnt = '0;
    w_free0    = '0;
    w_free1    = '0;
    w_have0    = 1'b0;
    w_have1    = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!r_valid[i]) begin
        w_free_cnt = w_free_cnt + 5'd1;
        if (!w_have0) begin
          w_have0 = 1'b1;
          w_free0 = IDX_W'(i);
        end else if (!w_have1) begin
          w_have1 = 1'b1;
          w_free1 = IDX_W'(i);
        end
      end
    end
  end

  assign rs_free_cnt = w_free_cnt;
  assign disp_ready  = (w_free_cnt >= 5'd2);

  // A lone slot 1 takes the lowest free row.
  always_comb begin
    w_alloc_en[0]  = disp_valid[0] & disp_ready;
    w_alloc_en[1]  = disp_valid[1] & disp_ready;
    w_alloc_idx[0] = w_free0;
    w_alloc_idx[1] = disp_valid[0] ? w_free1 : w_free0;
    for (int s = 0; s < 2; s++) begin
      w_src1[s] = src_resolve(disp_ps1[s], disp_src1_rdy[s], disp_src1_data[s]);
      w_src2[s] = src_resolve(disp_ps2[s], disp_src2_rdy[s], disp_src2_data[s]);
    end
  end

  always_comb begin
    w_elig      = r_valid & r_rdy1 & r_rdy2;
    w_grant     = '0;
    w_grant_idx = '0;
    w_taken     = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (fu_ready[f]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (!w_grant[f] && w_elig[i] && !w_taken[i]) begin
            w_grant[f]     = 1'b1;
            w_grant_idx[f] = IDX_W'(i);
            w_taken[i]     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_wb1[i] = wb_lookup(r_ps1[i]);
      w_wb2[i] = wb_lookup(r_ps2[i]);
      w_wk1[i] = r_valid[i] & ~r_rdy1[i] & w_wb1[i].hit;
      w_wk2[i] = r_valid[i] & ~r_rdy2[i] & w_wb2[i].hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_taken[i]) r_valid[i] <= 1'b0;
        if (w_wk1[i])   r_rdy1[i]  <= 1'b1;
        if (w_wk2[i])   r_rdy2[i]  <= 1'b1;
      end
      for (int s = 0; s < 2; s++) begin
        if (w_alloc_en[s]) begin
          r_valid[w_alloc_idx[s]] <= 1'b1;
          r_rdy1[w_alloc_idx[s]]  <= w_src1[s][DATA_W];
          r_rdy2[w_alloc_idx[s]]  <= w_src2[s][DATA_W];
        end
      end
    end
  end

  // Payload only matters while the row is valid, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_wk1[i]) r_data1[i] <= w_wb1[i].data;
      if (w_wk2[i]) r_data2[i] <= w_wb2[i].data;
    end
    for (int s = 0; s < 2; s++) begin
      if (w_alloc_en[s]) begin
        r_op[w_alloc_idx[s]]    <= disp_op[s];
        r_pd[w_alloc_idx[s]]    <= disp_pd[s];
        r_ps1[w_alloc_idx[s]]   <= disp_ps1[s];
        r_ps2[w_alloc_idx[s]]   <= disp_ps2[s];
        r_data1[w_alloc_idx[s]] <= w_src1[s][DATA_W-1:0];
        r_data2[w_alloc_idx[s]] <= w_src2[s][DATA_W-1:0];
        r_rob[w_alloc_idx[s]]   <= disp_rob[s];
      end
    end
  end

  // Issue register: ungranted FUs keep their last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= '0;
      iss_op    <= '0;
      iss_pd    <= '0;
      iss_rob   <= '0;
      iss_data1 <= '0;
      iss_data2 <= '0;
    end else if (flush) begin
      iss_valid <= '0;
    end else begin
      iss_valid <= w_grant;
      for (int f = 0; f < NUM_FU; f++) begin
        if (w_grant[f]) begin
          iss_op[f]    <= r_op[w_grant_idx[f]];
          iss_pd[f]    <= r_pd[w_grant_idx[f]];
          iss_rob[f]   <= r_rob[w_grant_idx[f]];
          iss_data1[f] <= r_data1[w_grant_idx[f]];
          iss_data2[f] <= r_data2[w_grant_idx[f]];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issues are queued as
// stimulus is driven and retired against the issue ports every cycle.
module tb_rs_issue_scheduler;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [1:0]        disp_valid;
  logic [1:0][6:0]   disp_op;
  logic [1:0][5:0]   disp_pd;
  logic [1:0][5:0]   disp_ps1;
  logic [1:0][5:0]   disp_ps2;
  logic [1:0]        disp_src1_rdy;
  logic [1:0]        disp_src2_rdy;
  logic [1:0][31:0]  disp_src1_data;
  logic [1:0][31:0]  disp_src2_data;
  logic [1:0][3:0]   disp_rob;
  logic              disp_ready;
  logic [4:0]        rs_free_cnt;
  logic [2:0]        wb_valid;
  logic [2:0][5:0]   wb_tag;
  logic [2:0][31:0]  wb_data;
  logic [2:0]        fu_ready;
  logic [2:0]        iss_valid;
  logic [2:0][6:0]   iss_op;
  logic [2:0][5:0]   iss_pd;
  logic [2:0][3:0]   iss_rob;
  logic [2:0][31:0]  iss_data1;
  logic [2:0][31:0]  iss_data2;

  rs_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pd(disp_pd),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
    .disp_rob(disp_rob), .disp_ready(disp_ready), .rs_free_cnt(rs_free_cnt),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_op(iss_op),
    .iss_pd(iss_pd), .iss_rob(iss_rob), .iss_data1(iss_data1),
    .iss_data2(iss_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          fu;
    logic [5:0]  pd;
    logic [3:0]  rob;
    logic [31:0] d1;
    logic [31:0] d2;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk;
  int  n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_iss(input int fu, input logic [5:0] pd, input logic [3:0] rob,
                                  input logic [31:0] d1, input logic [31:0] d2);
    sb_t e;
    e.fu = fu; e.pd = pd; e.rob = rob; e.d1 = d1; e.d2 = d2;
    sb_q.push_back(e);
  endfunction

  task automatic sb_check();
    sb_t e;
    for (int f = 0; f < 3; f++) begin
      if (iss_valid[f]) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_issue", 64'(iss_valid[f]), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("iss_fu", 64'(f), 64'(e.fu));
          chk("iss_pd", 64'(iss_pd[f]), 64'(e.pd));
          chk("iss_op", 64'(iss_op[f]), 64'({1'b0, e.pd}));
          chk("iss_rob", 64'(iss_rob[f]), 64'(e.rob));
          chk("iss_data1", 64'(iss_data1[f]), 64'(e.d1));
          chk("iss_data2", 64'(iss_data2[f]), 64'(e.d2));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic set_slot(input int s, input logic [5:0] pd, input logic [5:0] ps1,
                          input logic r1, input logic [31:0] d1, input logic [5:0] ps2,
                          input logic r2, input logic [31:0] d2, input logic [3:0] rob);
    disp_valid[s]     = 1'b1;
    disp_op[s]        = {1'b0, pd};
    disp_pd[s]        = pd;
    disp_ps1[s]       = ps1;
    disp_src1_rdy[s]  = r1;
    disp_src1_data[s] = d1;
    disp_ps2[s]       = ps2;
    disp_src2_rdy[s]  = r2;
    disp_src2_data[s] = d2;
    disp_rob[s]       = rob;
  endtask

  task automatic clr_inputs();
    disp_valid = '0; disp_op = '0; disp_pd = '0; disp_ps1 = '0; disp_ps2 = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0; disp_src1_data = '0; disp_src2_data = '0;
    disp_rob = '0; wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    fu_ready = 3'b111;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_free_cnt", 64'(rs_free_cnt), 64'd16);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_data1", 64'(iss_data1), 64'd0);

    // Two ready instructions; slot 0 uses tag 0 with junk data and rdy=0.
    set_slot(0, 6'd33, 6'd0, 1'b0, 32'hFFFF_FFFF, 6'd0, 1'b0, 32'h1234, 4'd1);
    set_slot(1, 6'd34, 6'd5, 1'b1, 32'h11, 6'd6, 1'b1, 32'h22, 4'd2);
    tick();
    clr_inputs();
    chk("t1_free_after_disp", 64'(rs_free_cnt), 64'd14);
    exp_iss(0, 6'd33, 4'd1, 32'h0, 32'h0);
    exp_iss(1, 6'd34, 4'd2, 32'h11, 32'h22);
    tick();
    chk("t1_iss_valid", 64'(iss_valid), 64'b011);
    chk("t1_free_after_iss", 64'(rs_free_cnt), 64'd16);
    tick();
    chk("t1_iss_valid_pulse", 64'(iss_valid), 64'd0);

    // Wakeup two cycles after dispatch.
    set_slot(0, 6'd20, 6'd40, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 4'd3);
    tick();
    clr_inputs();
    tick();
    wb_valid = 3'b101;
    wb_tag[0] = 6'd41; wb_data[0] = 32'h1111;
    wb_tag[2] = 6'd40; wb_data[2] = 32'hDEAD;
    tick();
    clr_inputs();
    chk("t2_not_yet", 64'(iss_valid), 64'd0);
    exp_iss(0, 6'd20, 4'd3, 32'hDEAD, 32'h0);
    tick();
    chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // Fill all rows with a not-ready source.
    for (int k = 0; k < 7; k++) begin
      set_slot(0, 6'(2*k+1), 6'd50, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 4'(2*k));
      set_slot(1, 6'(2*k+2), 6'd50, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 4'(2*k+1));
      tick();
    end
    clr_inputs();
    chk("t3_free_2", 64'(rs_free_cnt), 64'd2);
    chk("t3_ready_at_2", 64'(disp_ready), 64'd1);
    set_slot(0, 6'd15, 6'd50, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 4'd14);
    set_slot(1, 6'd16, 6'd50, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 4'd15);
    tick();
    chk("t3_free_0", 64'(rs_free_cnt), 64'd0);
    chk("t3_ready_full", 64'(disp_ready), 64'd0);
    set_slot(0, 6'd61, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 4'd0);
    set_slot(1, 6'd62, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 4'd0);
    tick();
    clr_inputs();
    chk("t3_ignored_free", 64'(rs_free_cnt), 64'd0);
    fu_ready = 3'b000;
    wb_valid = 3'b010; wb_tag[1] = 6'd50; wb_data[1] = 32'h50;
    tick();
    clr_inputs();
    fu_ready = 3'b001;
    exp_iss(0, 6'd1, 4'd0, 32'h50, 32'h0);
    tick();
    chk("t3_free_1", 64'(rs_free_cnt), 64'd1);
    chk("t3_ready_1free", 64'(disp_ready), 64'd0);
    fu_ready = 3'b000;
    set_slot(0, 6'd60, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 4'd0);
    tick();
    clr_inputs();
    chk("t3_single_refused", 64'(rs_free_cnt), 64'd1);
    fu_ready = 3'b111;
    for (int c = 0; c < 5; c++) begin
      for (int f = 0; f < 3; f++) begin
        exp_iss(f, 6'(3*c+f+2), 4'(3*c+f+1), 32'h50, 32'h0);
      end
      tick();
    end
    chk("t3_drained_free", 64'(rs_free_cnt), 64'd16);
    chk("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    // Five eligible rows, FU1 busy.
    fu_ready = 3'b000;
    for (int k = 0; k < 5; k++) begin
      set_slot(0, 6'(21+k), 6'd0, 1'b0, 32'h0, 6'd7, 1'b1, 32'(100+k), 4'(k));
      tick();
    end
    clr_inputs();
    fu_ready = 3'b101;
    exp_iss(0, 6'd21, 4'd0, 32'h0, 32'd100);
    exp_iss(2, 6'd22, 4'd1, 32'h0, 32'd101);
    tick();
    chk("t4_iss_valid_101", 64'(iss_valid), 64'b101);
    chk("t4_fu1_hold", 64'(iss_pd[1]), 64'd15);
    fu_ready = 3'b111;
    exp_iss(0, 6'd23, 4'd2, 32'h0, 32'd102);
    exp_iss(1, 6'd24, 4'd3, 32'h0, 32'd103);
    exp_iss(2, 6'd25, 4'd4, 32'h0, 32'd104);
    tick();
    chk("t4_iss_valid_111", 64'(iss_valid), 64'b111);

    // Same-cycle wakeup of a dispatching source; port 0 beats port 2.
    set_slot(0, 6'd30, 6'd0, 1'b0, 32'h0, 6'd45, 1'b0, 32'h999, 4'd9);
    wb_valid = 3'b101;
    wb_tag[0] = 6'd45; wb_data[0] = 32'd7;
    wb_tag[2] = 6'd45; wb_data[2] = 32'd9;
    tick();
    clr_inputs();
    exp_iss(0, 6'd30, 4'd9, 32'h0, 32'd7);
    tick();
    chk("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // Flush with ten valid rows, one of them eligible.
    fu_ready = 3'b000;
    for (int k = 0; k < 5; k++) begin
      set_slot(0, 6'(2*k+1), 6'd55, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 4'(2*k));
      set_slot(1, 6'(2*k+2), 6'd55, (k == 4), 32'h0, 6'd0, 1'b0, 32'h0, 4'(2*k+1));
      tick();
    end
    clr_inputs();
    chk("t6_free_6", 64'(rs_free_cnt), 64'd6);
    fu_ready = 3'b111;
    flush = 1'b1;
    set_slot(0, 6'd50, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 4'd0);
    wb_valid = 3'b001; wb_tag[0] = 6'd55; wb_data[0] = 32'h55;
    tick();
    flush = 1'b0;
    clr_inputs();
    chk("t6_flush_free", 64'(rs_free_cnt), 64'd16);
    chk("t6_flush_iss_valid", 64'(iss_valid), 64'd0);
    tick();
    chk("t6_flush_discard", 64'(rs_free_cnt), 64'd16);

    // Asynchronous reset while an issue is on the outputs.
    set_slot(0, 6'd44, 6'd3, 1'b1, 32'hABC, 6'd0, 1'b0, 32'h0, 4'd5);
    set_slot(1, 6'd45, 6'd57, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 4'd6);
    tick();
    clr_inputs();
    exp_iss(0, 6'd44, 4'd5, 32'hABC, 32'h0);
    tick();
    chk("t7_pre_rst_valid", 64'(iss_valid), 64'b001);
    chk("t7_pre_rst_free", 64'(rs_free_cnt), 64'd15);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("t7_rst_iss_pd", 64'(iss_pd[0]), 64'd0);
    chk("t7_rst_iss_data1", 64'(iss_data1[0]), 64'd0);
    chk("t7_rst_free", 64'(rs_free_cnt), 64'd16);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("t7_post_rst_idle", 64'(iss_valid), 64'd0);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
